// File: rtl/timer_bcd_updown.sv
// Up/down BCD timer: prescaler-generated count tick driving a multi-digit BCD counter
// with preset load (clamped), pause/resume, terminal detection and stop/auto-reload.
module timer_bcd_updown #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int DIGITS      = 4,
    parameter int TIME_MAX    = 9999,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] preset,
    output logic [4*DIGITS-1:0] cur_time,
    output logic                tick,
    output logic                done,
    output logic                expired
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        PAUSED,
        RUNNING,
        EXPIRED
    } state_t;

    function automatic logic [W-1:0] to_bcd(input int unsigned value);
        logic [W-1:0] r;
        int unsigned  v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0]  MAX_BCD = to_bcd(TIME_MAX);
    localparam logic [PW-1:0] LAST    = PW'(TICK_DIV - 1);

    state_t        state, nxt_state;
    logic [PW-1:0] presc, nxt_presc;
    logic [W-1:0]  nxt_time;
    logic          nxt_tick, nxt_done;

    logic [W-1:0]  load_value;
    logic [W-1:0]  terminal;
    logic [W-1:0]  stepped;

    // Digit-valid BCD values order the same as their decimal values, so a plain
    // unsigned compare against MAX_BCD is enough once the digits are checked.
    always_comb begin
        load_value = preset;
        if (!bcd_ok(preset) || (preset > MAX_BCD)) load_value = MAX_BCD;
    end

    always_comb begin
        terminal = up ? MAX_BCD : '0;
        stepped  = up ? bcd_inc(cur_time) : bcd_dec(cur_time);
    end

    always_comb begin
        nxt_state = state;
        nxt_presc = presc;
        nxt_time  = cur_time;
        nxt_tick  = 1'b0;
        nxt_done  = 1'b0;

        if (load) begin
            nxt_time  = load_value;
            nxt_presc = '0;
            nxt_state = en ? RUNNING : PAUSED;
        end else begin
            case (state)
                EXPIRED: begin
                    nxt_state = EXPIRED;
                end
                default: begin
                    if (!en) begin
                        nxt_state = PAUSED;
                    end else begin
                        nxt_state = RUNNING;
                        if (presc == LAST) begin
                            nxt_presc = '0;
                            nxt_tick  = 1'b1;
                            if (cur_time == terminal) begin
                                if (AUTO_RELOAD != 0) begin
                                    nxt_time = up ? '0 : MAX_BCD;
                                end else begin
                                    nxt_done  = 1'b1;
                                    nxt_state = EXPIRED;
                                end
                            end else begin
                                nxt_time = stepped;
                                if (stepped == terminal) begin
                                    nxt_done = 1'b1;
                                    if (AUTO_RELOAD == 0) nxt_state = EXPIRED;
                                end
                            end
                        end else begin
                            nxt_presc = presc + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= PAUSED;
            presc    <= '0;
            cur_time <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= nxt_state;
            presc    <= nxt_presc;
            cur_time <= nxt_time;
            tick     <= nxt_tick;
            done     <= nxt_done;
            expired  <= (nxt_state == EXPIRED);
        end
    end

endmodule

// File: tb/tb_timer_bcd_updown.sv
// Bench for timer_bcd_updown: three instances (stop, auto-reload, TICK_DIV=1) share
// stimulus and are checked every cycle against a decimal reference model.
module tb_timer_bcd_updown;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] preset;

    logic [7:0] cur_a, cur_b, cur_c;
    logic       tick_a, tick_b, tick_c;
    logic       done_a, done_b, done_c;
    logic       exp_a, exp_b, exp_c;

    int total = 0;
    int bad   = 0;

    timer_bcd_updown #(.TICK_DIV(4), .DIGITS(2), .TIME_MAX(59), .AUTO_RELOAD(0)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .preset(preset),
        .cur_time(cur_a), .tick(tick_a), .done(done_a), .expired(exp_a)
    );

    timer_bcd_updown #(.TICK_DIV(4), .DIGITS(2), .TIME_MAX(59), .AUTO_RELOAD(1)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .preset(preset),
        .cur_time(cur_b), .tick(tick_b), .done(done_b), .expired(exp_b)
    );

    timer_bcd_updown #(.TICK_DIV(1), .DIGITS(2), .TIME_MAX(59), .AUTO_RELOAD(1)) dut_c (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .preset(preset),
        .cur_time(cur_c), .tick(tick_c), .done(done_c), .expired(exp_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: decimal value plus a cycle counter and a halted flag.
    int mdiv [3] = '{4, 4, 1};
    int mar  [3] = '{0, 1, 1};
    int mval [3];
    int mcnt [3];
    int mtick[3];
    int mdone[3];
    int mhalt[3];

    function automatic logic [7:0] enc(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int preset_value(input logic [7:0] p);
        int hi, lo, v;
        hi = int'(p[7:4]);
        lo = int'(p[3:0]);
        if (hi > 9 || lo > 9) return 59;
        v = hi * 10 + lo;
        return (v > 59) ? 59 : v;
    endfunction

    task automatic model_step();
        int term;
        for (int k = 0; k < 3; k++) begin
            mtick[k] = 0;
            mdone[k] = 0;
            if (!rstn) begin
                mval[k] = 0; mcnt[k] = 0; mhalt[k] = 0;
            end else if (load) begin
                mval[k] = preset_value(preset); mcnt[k] = 0; mhalt[k] = 0;
            end else if (mhalt[k] == 0 && en) begin
                if (mcnt[k] == mdiv[k] - 1) begin
                    mcnt[k]  = 0;
                    mtick[k] = 1;
                    term     = up ? 59 : 0;
                    if (mval[k] == term) begin
                        if (mar[k] != 0) mval[k] = up ? 0 : 59;
                        else begin mdone[k] = 1; mhalt[k] = 1; end
                    end else begin
                        mval[k] = up ? mval[k] + 1 : mval[k] - 1;
                        if (mval[k] == term) begin
                            mdone[k] = 1;
                            if (mar[k] == 0) mhalt[k] = 1;
                        end
                    end
                end else begin
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a.cur_time", cur_a, enc(mval[0]));
        check("a.tick", 8'(tick_a), 8'(mtick[0]));
        check("a.done", 8'(done_a), 8'(mdone[0]));
        check("a.expired", 8'(exp_a), 8'(mhalt[0]));
        check("b.cur_time", cur_b, enc(mval[1]));
        check("b.tick", 8'(tick_b), 8'(mtick[1]));
        check("b.done", 8'(done_b), 8'(mdone[1]));
        check("b.expired", 8'(exp_b), 8'(mhalt[1]));
        check("c.cur_time", cur_c, enc(mval[2]));
        check("c.tick", 8'(tick_c), 8'(mtick[2]));
        check("c.done", 8'(done_c), 8'(mdone[2]));
        check("c.expired", 8'(exp_c), 8'(mhalt[2]));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    task automatic do_load(input logic [7:0] p);
        load   = 1'b1;
        preset = p;
        cyc(1);
        load   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; preset = 8'h00;

        // reset held with en=1, then first tick TICK_DIV cycles after release
        cyc(2);
        check("rst.cur_time", cur_a, 8'h00);
        check("rst.expired", 8'(exp_a), 8'h0);
        rstn = 1'b1;
        cyc(3);
        check("rst.no_tick", 8'(tick_a), 8'h0);
        cyc(1);

        // up-count to terminal and stop
        up = 1'b1; en = 1'b1;
        do_load(8'h57);
        cyc(8);
        check("up.final", cur_a, 8'h59);
        check("up.expired", 8'(exp_a), 8'h1);
        cyc(20);
        check("up.hold", cur_a, 8'h59);

        // down-count through zero (wrap on the reload instance), then 10->09 borrow
        up = 1'b0;
        do_load(8'h01);
        cyc(12);
        check("down.wrap_b", cur_b, 8'h58);
        do_load(8'h10);
        cyc(4);
        check("down.borrow", cur_a, 8'h09);

        // pause two cycles into a period
        up = 1'b1;
        do_load(8'h30);
        cyc(2);
        en = 1'b0;
        cyc(10);
        check("pause.hold", cur_a, 8'h30);
        en = 1'b1;
        cyc(1);
        check("pause.no_tick", 8'(tick_a), 8'h0);
        cyc(1);
        check("pause.tick", 8'(tick_a), 8'h1);
        check("pause.value", cur_a, 8'h31);

        // load clamping, load out of EXPIRED, load coincident with a tick
        do_load(8'h75);
        check("clamp.75", cur_a, 8'h59);
        do_load(8'h3A);
        check("clamp.3A", cur_a, 8'h59);
        cyc(4);
        check("exp.set", 8'(exp_a), 8'h1);
        do_load(8'h20);
        check("exp.clear", 8'(exp_a), 8'h0);
        do_load(8'h10);
        cyc(3);
        do_load(8'h05);
        check("coinc.value", cur_a, 8'h05);
        check("coinc.tick", 8'(tick_a), 8'h0);

        // direction flip, preset already at the down terminal
        do_load(8'h18);
        cyc(8);
        check("flip.at20", cur_a, 8'h20);
        up = 1'b0;
        do_load(8'h00);
        cyc(4);
        check("flip.tick", 8'(tick_a), 8'h1);
        check("flip.done", 8'(done_a), 8'h1);
        check("flip.expired", 8'(exp_a), 8'h1);
        check("flip.value", cur_a, 8'h00);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 199) != 0);
            en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) up = ~up;
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0) preset = enc(int'($urandom_range(0, 59)));
            else preset = 8'($urandom);
            cyc(1);
        end
        load = 1'b0;
        rstn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
